data_cache_2way: RTL and testbench

Parametrised two-way set-associative write-back, write-allocate data cache between the pipeline MEM stage and the line-wide data memory. It is the successor to the 8-entry direct-mapped byte cache. It adds configurable set count and line size, per-set LRU replacement, sub-word stores, and a registered miss FSM that performs write-back followed by line fetch over a busywait handshake.

---
 rtl/dcache_pkg.sv | 56 +++++
 rtl/dcache_way.sv | 77 +++++++
 rtl/data_cache_2way.sv | 222 ++++++++++++++++++++++
 tb/tb_data_cache_2way.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the two-way data cache.
//   state_t        miss FSM states (IDLE, WRITEBACK, FETCH)
//   SIZE_*         cpu_size store-width encodings (2'b11 behaves as a word)
//   offset_bits / index_bits / tag_bits / word_sel_bits : address split widths
//   lane_mask / store_align : byte-lane enables and lane-replicated store data
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  function automatic int offset_bits(input int words_per_line);
    return $clog2(4 * words_per_line);
  endfunction

  function automatic int index_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_bits(input int addr_w, input int num_sets,
                                  input int words_per_line);
    return addr_w - index_bits(num_sets) - offset_bits(words_per_line);
  endfunction

  // A one-word line still needs a 1-bit select so vectors stay legal.
  function automatic int word_sel_bits(input int words_per_line);
    return (words_per_line > 1) ? $clog2(words_per_line) : 1;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 4'b0001 << addr_lo;
      SIZE_H:  return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store data across all lanes so the mask
  // alone decides which bytes land.
  function automatic logic [31:0] store_align(input logic [1:0] size,
                                              input logic [31:0] data);
    case (size)
      SIZE_B:  return {4{data[7:0]}};
      SIZE_H:  return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/dcache_way.sv
// dcache_way: one way of the two-way cache.
//   Holds per-set valid, dirty, tag and line storage.
//   clock, reset        : clock, async active-high reset (clears valid/dirty)
//   rd_index, rd_tag    : lookup set and tag; hit = valid && tag match
//   valid_out, dirty_out, tag_out, line_out : state of the looked-up set
//   wr_index            : set written by fill or store
//   fill_en, fill_tag, fill_line : whole-line fill, marks valid and clean
//   store_en, store_word, store_mask, store_data : lane-masked word store,
//                         marks the line dirty
module dcache_way
  import dcache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int NUM_SETS       = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [index_bits(NUM_SETS)-1:0]                  rd_index,
  input  logic [tag_bits(ADDR_W, NUM_SETS, WORDS_PER_LINE)-1:0] rd_tag,
  output logic                                             hit,
  output logic                                             valid_out,
  output logic                                             dirty_out,
  output logic [tag_bits(ADDR_W, NUM_SETS, WORDS_PER_LINE)-1:0] tag_out,
  output logic [32*WORDS_PER_LINE-1:0]                     line_out,
  input  logic [index_bits(NUM_SETS)-1:0]                  wr_index,
  input  logic                                             fill_en,
  input  logic [tag_bits(ADDR_W, NUM_SETS, WORDS_PER_LINE)-1:0] fill_tag,
  input  logic [32*WORDS_PER_LINE-1:0]                     fill_line,
  input  logic                                             store_en,
  input  logic [word_sel_bits(WORDS_PER_LINE)-1:0]         store_word,
  input  logic [3:0]                                       store_mask,
  input  logic [31:0]                                      store_data
);

  localparam int TAG_W  = tag_bits(ADDR_W, NUM_SETS, WORDS_PER_LINE);
  localparam int LINE_W = 32 * WORDS_PER_LINE;

  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   line_mem [NUM_SETS];

  assign valid_out = valid[rd_index];
  assign dirty_out = dirty[rd_index];
  assign tag_out   = tag_mem[rd_index];
  assign line_out  = line_mem[rd_index];
  assign hit       = valid[rd_index] && (tag_mem[rd_index] == rd_tag);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[wr_index] <= 1'b1;
      dirty[wr_index] <= 1'b0;
    end else if (store_en) begin
      dirty[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag and line arrays carry no reset; valid gates every use, so
  // clearing them would only cost reset fan-out and block RAM mapping.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_mem[wr_index]  <= fill_tag;
      line_mem[wr_index] <= fill_line;
    end else if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (store_mask[b]) begin
          line_mem[wr_index][{store_word, 2'(b), 3'b000} +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_cache_2way.sv
// data_cache_2way: two-way set-associative write-back, write-allocate data
// cache with per-set LRU and a WRITEBACK -> FETCH miss FSM.
//   clock, reset   : clock, async active-high reset
//   cpu_read/cpu_write/cpu_size/cpu_address/cpu_writedata : pipeline request
//   cpu_readdata   : aligned word holding the addressed byte (0 when no hit)
//   cpu_busywait   : stall, combinational
//   mem_read/mem_write/mem_address/mem_writedata : registered line request
//   mem_readdata, mem_busywait : memory response
// Optional feature macro DCACHE_STATS_EN adds 32-bit hit_count and
// miss_count outputs.
module data_cache_2way
  import dcache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int NUM_SETS       = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            cpu_read,
  input  logic                            cpu_write,
  input  logic [1:0]                      cpu_size,
  input  logic [ADDR_W-1:0]               cpu_address,
  input  logic [31:0]                     cpu_writedata,
  output logic [31:0]                     cpu_readdata,
  output logic                            cpu_busywait,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [ADDR_W-1:0]               mem_address,
  output logic [32*WORDS_PER_LINE-1:0]    mem_writedata,
  input  logic [32*WORDS_PER_LINE-1:0]    mem_readdata,
  input  logic                            mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                     hit_count,
  output logic [31:0]                     miss_count
`endif
);

  localparam int OFF_W  = offset_bits(WORDS_PER_LINE);
  localparam int IDX_W  = index_bits(NUM_SETS);
  localparam int TAG_W  = tag_bits(ADDR_W, NUM_SETS, WORDS_PER_LINE);
  localparam int WSEL_W = word_sel_bits(WORDS_PER_LINE);
  localparam int LINE_W = 32 * WORDS_PER_LINE;

  state_t              state;
  logic [NUM_SETS-1:0] lru;          // 1 = way1 is least recently used
  logic [IDX_W-1:0]    miss_index;
  logic [TAG_W-1:0]    miss_tag;
  logic                victim_way;

  logic [IDX_W-1:0]  cpu_index, lookup_index, wr_index;
  logic [TAG_W-1:0]  cpu_tag, tag0, tag1, victim_tag;
  logic [WSEL_W-1:0] word_sel;
  logic              hit0, hit1, hit, request;
  logic              valid0, valid1, dirty0, dirty1;
  logic              victim_sel, victim_dirty;
  logic [LINE_W-1:0] line0, line1, hit_line;
  logic              fill_en, store_en;
  logic [3:0]        store_mask;
  logic [31:0]       store_data;

  assign cpu_index = cpu_address[OFF_W +: IDX_W];
  assign cpu_tag   = cpu_address[ADDR_W-1 -: TAG_W];

  generate
    if (WORDS_PER_LINE > 1) begin : g_word_sel
      assign word_sel = cpu_address[OFF_W-1:2];
    end else begin : g_word_sel_one
      assign word_sel = 1'b0;
    end
  endgenerate

  assign request = cpu_read || cpu_write;
  assign hit     = hit0 || hit1;

  // While a miss is in flight the arrays are addressed by the captured
  // miss set so the victim line stays on mem_writedata.
  assign lookup_index = (state == IDLE)  ? cpu_index  : miss_index;
  assign wr_index     = (state == FETCH) ? miss_index : cpu_index;

  assign fill_en    = (state == FETCH) && !mem_busywait;
  assign store_en   = (state == IDLE) && cpu_write && !cpu_read && hit;
  assign store_mask = lane_mask(cpu_size, cpu_address[1:0]);
  assign store_data = store_align(cpu_size, cpu_writedata);

  dcache_way #(
    .ADDR_W         (ADDR_W),
    .NUM_SETS       (NUM_SETS),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_way0 (
    .clock      (clock),
    .reset      (reset),
    .rd_index   (lookup_index),
    .rd_tag     (cpu_tag),
    .hit        (hit0),
    .valid_out  (valid0),
    .dirty_out  (dirty0),
    .tag_out    (tag0),
    .line_out   (line0),
    .wr_index   (wr_index),
    .fill_en    (fill_en && !victim_way),
    .fill_tag   (miss_tag),
    .fill_line  (mem_readdata),
    .store_en   (store_en && hit0),
    .store_word (word_sel),
    .store_mask (store_mask),
    .store_data (store_data)
  );

  dcache_way #(
    .ADDR_W         (ADDR_W),
    .NUM_SETS       (NUM_SETS),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_way1 (
    .clock      (clock),
    .reset      (reset),
    .rd_index   (lookup_index),
    .rd_tag     (cpu_tag),
    .hit        (hit1),
    .valid_out  (valid1),
    .dirty_out  (dirty1),
    .tag_out    (tag1),
    .line_out   (line1),
    .wr_index   (wr_index),
    .fill_en    (fill_en && victim_way),
    .fill_tag   (miss_tag),
    .fill_line  (mem_readdata),
    .store_en   (store_en && hit1),
    .store_word (word_sel),
    .store_mask (store_mask),
    .store_data (store_data)
  );

  // Victim order: invalid way0, invalid way1, then the LRU way.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    victim_sel = lru[cpu_index];
    if (!valid0) begin
      victim_sel = 1'b0;
    end else if (!valid1) begin
      victim_sel = 1'b1;
    end
  end

  assign victim_dirty = victim_sel ? dirty1 : dirty0;
  assign victim_tag   = victim_sel ? tag1 : tag0;

  assign hit_line      = hit1 ? line1 : line0;
  assign cpu_readdata  = ((state == IDLE) && hit) ? hit_line[{word_sel, 5'd0} +: 32] : 32'd0;
  assign mem_writedata = (state == WRITEBACK) ? (victim_way ? line1 : line0) : '0;

  // Held low during reset so the pipeline never sees a stall it cannot clear.
  assign cpu_busywait = !reset && ((state != IDLE) || (request && !hit));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      miss_index  <= '0;
      miss_tag    <= '0;
      victim_way  <= 1'b0;
      lru         <= '0;
`ifdef DCACHE_STATS_EN
      hit_count   <= 32'd0;
      miss_count  <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (request && hit) begin
            lru[cpu_index] <= ~hit1;
`ifdef DCACHE_STATS_EN
            hit_count <= hit_count + 32'd1;
`endif
          end else if (request) begin
            miss_index <= cpu_index;
            miss_tag   <= cpu_tag;
            victim_way <= victim_sel;
`ifdef DCACHE_STATS_EN
            miss_count <= miss_count + 32'd1;
`endif
            if (victim_dirty) begin
              state       <= WRITEBACK;
              mem_write   <= 1'b1;
              mem_address <= {victim_tag, cpu_index, {OFF_W{1'b0}}};
            end else begin
              state       <= FETCH;
              mem_read    <= 1'b1;
              mem_address <= {cpu_tag, cpu_index, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (!mem_busywait) begin
            state       <= FETCH;
            mem_write   <= 1'b0;
            mem_read    <= 1'b1;
            mem_address <= {miss_tag, miss_index, {OFF_W{1'b0}}};
          end
        end
        FETCH: begin
          if (!mem_busywait) begin
            state    <= IDLE;
            mem_read <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache_2way.sv
// tb_data_cache_2way: directed, table-driven bench for data_cache_2way with a
// line-wide memory model of configurable busy latency.
module tb_data_cache_2way;

  localparam int LINE_W = 128;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_read, cpu_write;
  logic [1:0]        cpu_size;
  logic [31:0]       cpu_address, cpu_writedata, cpu_readdata;
  logic              cpu_busywait;
  logic              mem_read, mem_write, mem_busywait;
  logic [31:0]       mem_address;
  logic [LINE_W-1:0] mem_writedata, mem_readdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]       hit_count, miss_count;
`endif

  data_cache_2way #(
    .ADDR_W         (32),
    .NUM_SETS       (8),
    .WORDS_PER_LINE (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_size      (cpu_size),
    .cpu_address   (cpu_address),
    .cpu_writedata (cpu_writedata),
    .cpu_readdata  (cpu_readdata),
    .cpu_busywait  (cpu_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  always #5 clock = ~clock;

  // Memory model: unwritten word at byte address a reads 0xA0000000 | a.
  int          mem_latency = 3;
  int          busy_cnt = 0;
  logic [255:0] written = '0;
  logic [31:0] wr_mem [256];

  typedef struct {
    logic              wr;
    logic [31:0]       addr;
    logic [LINE_W-1:0] data;
  } mem_txn_t;
  mem_txn_t log_q[$];

  assign mem_busywait = (mem_read || mem_write) && (busy_cnt < mem_latency);

  always_comb begin
    mem_readdata = '0;
    for (int w = 0; w < 4; w++) begin
      if (written[{mem_address[9:4], 2'(w)}])
        mem_readdata[32*w +: 32] = wr_mem[{mem_address[9:4], 2'(w)}];
      else
        mem_readdata[32*w +: 32] = 32'hA000_0000 | {22'd0, mem_address[9:4], 2'(w), 2'b00};
    end
  end

  always @(posedge clock) begin
    if (mem_read || mem_write) begin
      if (!mem_busywait) begin
        log_q.push_back('{mem_write, mem_address, mem_writedata});
        if (mem_write) begin
          for (int w = 0; w < 4; w++) begin
            wr_mem[{mem_address[9:4], 2'(w)}]  <= mem_writedata[32*w +: 32];
            written[{mem_address[9:4], 2'(w)}] <= 1'b1;
          end
        end
        busy_cnt <= 0;
      end else begin
        busy_cnt <= busy_cnt + 1;
      end
    end else begin
      busy_cnt <= 0;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] actual,
                       input logic [LINE_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One request: drive at negedge, sample 1 ns later, count stalled cycles.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int stall, output logic [31:0] rdata);
    @(negedge clock);
    cpu_read = rd;
    cpu_write = wr;
    cpu_size = sz;
    cpu_address = addr;
    cpu_writedata = wdata;
    stall = 0;
    #1;
    while (cpu_busywait) begin
      if (stall >= 100) begin
        checks++;
        errors++;
        $display("FAIL timeout: busywait stuck at addr %0h", addr);
        break;
      end
      stall++;
      @(negedge clock);
      #1;
    end
    rdata = cpu_readdata;
  endtask

  task automatic go_idle();
    @(negedge clock);
    cpu_read = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr,
                          input int exp_stall, input logic [31:0] exp_data);
    int s;
    logic [31:0] d;
    access(1'b1, 1'b0, 2'b10, addr, 32'd0, s, d);
    check({name, " stall"}, LINE_W'(s), LINE_W'(exp_stall));
    check({name, " data"}, LINE_W'(d), LINE_W'(exp_data));
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_stall;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int base, s;
    logic [31:0] d;

    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_size = 2'b00;
    cpu_address = 32'd0;
    cpu_writedata = 32'd0;

    vecs[0]  = '{1, 0, 2'b10, 32'h40, 32'h0,        1, 32'hA000_0040, 5};
    vecs[1]  = '{1, 0, 2'b10, 32'h44, 32'h0,        1, 32'hA000_0044, 0};
    vecs[2]  = '{0, 1, 2'b00, 32'h41, 32'hAB,       0, 32'h0,         0};
    vecs[3]  = '{1, 0, 2'b10, 32'h40, 32'h0,        1, 32'hA000_AB40, 0};
    vecs[4]  = '{0, 1, 2'b01, 32'h47, 32'h1234,     0, 32'h0,         0};
    vecs[5]  = '{1, 0, 2'b10, 32'h44, 32'h0,        1, 32'h1234_0044, 0};
    vecs[6]  = '{0, 1, 2'b10, 32'h4B, 32'hDEADBEEF, 0, 32'h0,         0};
    vecs[7]  = '{1, 0, 2'b10, 32'h48, 32'h0,        1, 32'hDEAD_BEEF, 0};
    vecs[8]  = '{0, 1, 2'b11, 32'h4C, 32'h55,       0, 32'h0,         0};
    vecs[9]  = '{1, 1, 2'b10, 32'h4C, 32'hFFFFFFFF, 1, 32'h0000_0055, 0};
    vecs[10] = '{1, 0, 2'b10, 32'h4C, 32'h0,        1, 32'h0000_0055, 0};
    vecs[11] = '{0, 1, 2'b00, 32'h42, 32'h123456CD, 0, 32'h0,         0};
    vecs[12] = '{1, 0, 2'b10, 32'h40, 32'h0,        1, 32'hA0CD_AB40, 0};

    // Reset values, sampled mid-cycle while reset is held.
    #12;
    check("rst busywait", LINE_W'(cpu_busywait), '0);
    check("rst mem_read", LINE_W'(mem_read), '0);
    check("rst mem_write", LINE_W'(mem_write), '0);
    check("rst mem_address", LINE_W'(mem_address), '0);
    check("rst mem_writedata", mem_writedata, '0);
    check("rst readdata", LINE_W'(cpu_readdata), '0);
    @(negedge clock);
    reset = 1'b0;

    // Fill, hits and sub-word stores on line 0x40 with L=3.
    mem_latency = 3;
    base = log_q.size();
    for (int i = 0; i < 13; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wdata, s, d);
      check($sformatf("vec%0d stall", i), LINE_W'(s), LINE_W'(vecs[i].exp_stall));
      if (vecs[i].chk_rd)
        check($sformatf("vec%0d data", i), LINE_W'(d), LINE_W'(vecs[i].exp_rd));
    end
    go_idle();
    check("fill txn count", LINE_W'(log_q.size() - base), LINE_W'(1));
    check("fill txn is read", LINE_W'(log_q[base].wr), '0);
    check("fill txn addr", LINE_W'(log_q[base].addr), LINE_W'(32'h40));

    // Set conflict with L=1: LRU evicts 0x080, keeps 0x000.
    do_reset();
    mem_latency = 1;
    rd_check("cf fill0", 32'h000, 3, 32'hA000_0000);
    rd_check("cf fill80", 32'h080, 3, 32'hA000_0080);
    rd_check("cf hit0", 32'h000, 0, 32'hA000_0000);
    base = log_q.size();
    rd_check("cf fill100", 32'h104, 3, 32'hA000_0104);
    check("cf txn addr", LINE_W'(log_q[base].addr), LINE_W'(32'h100));
    check("cf txn is read", LINE_W'(log_q[base].wr), '0);
    rd_check("cf keep0", 32'h000, 0, 32'hA000_0000);
    rd_check("cf lost80", 32'h080, 3, 32'hA000_0080);
    go_idle();

    // Dirty eviction with L=2: write-back of 0x000 then fetch of 0x100.
    do_reset();
    mem_latency = 2;
    access(1'b0, 1'b1, 2'b10, 32'h000, 32'h1122_3344, s, d);
    check("dv store stall", LINE_W'(s), LINE_W'(4));
    rd_check("dv fill80", 32'h080, 4, 32'hA000_0080);
    base = log_q.size();
    rd_check("dv evict", 32'h100, 7, 32'hA000_0100);
    check("dv txn count", LINE_W'(log_q.size() - base), LINE_W'(2));
    check("dv wb is write", LINE_W'(log_q[base].wr), LINE_W'(1));
    check("dv wb addr", LINE_W'(log_q[base].addr), '0);
    check("dv wb data", log_q[base].data,
          {32'hA000_000C, 32'hA000_0008, 32'hA000_0004, 32'h1122_3344});
    check("dv fetch is read", LINE_W'(log_q[base+1].wr), '0);
    check("dv fetch addr", LINE_W'(log_q[base+1].addr), LINE_W'(32'h100));
    rd_check("dv reload", 32'h000, 4, 32'h1122_3344);
    go_idle();

    // Reset asserted mid-FETCH; the partial fill must not validate the line.
    do_reset();
    mem_latency = 5;
    @(negedge clock);
    cpu_read = 1'b1;
    cpu_write = 1'b0;
    cpu_address = 32'h40;
    repeat (3) @(negedge clock);
    #1;
    check("rf in fetch", LINE_W'(mem_read), LINE_W'(1));
    reset = 1'b1;
    #1;
    check("rf mem_read", LINE_W'(mem_read), '0);
    check("rf busywait", LINE_W'(cpu_busywait), '0);
    check("rf mem_address", LINE_W'(mem_address), '0);
    check("rf readdata", LINE_W'(cpu_readdata), '0);
    cpu_read = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    rd_check("rf reread", 32'h40, 7, 32'hA000_0040);
    go_idle();

`ifdef DCACHE_STATS_EN
    // Two misses (each ends in a hit cycle) plus one plain hit.
    do_reset();
    mem_latency = 1;
    rd_check("st a", 32'h000, 3, 32'hA000_0000);
    rd_check("st b", 32'h004, 0, 32'hA000_0004);
    rd_check("st c", 32'h200, 3, 32'hA000_0200);
    go_idle();
    #1;
    check("st hit_count", LINE_W'(hit_count), LINE_W'(3));
    check("st miss_count", LINE_W'(miss_count), LINE_W'(2));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
